// File: rtl/game_sequencer_pkg.sv
// Shared encodings and BCD helpers for the FlappyBird game sequencer.
// Optional feature macro used by the top: HIGH_SCORE_EN.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Elaboration-time only: turns a decimal parameter into its 3-digit BCD form.
    function automatic logic [11:0] to_bcd3(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Digit-wise magnitude compare, most-significant digit first.
    function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
        for (int unsigned i = 3; i > 0; i--) begin
            if (a[4*i-1 -: 4] != b[4*i-1 -: 4])
                return a[4*i-1 -: 4] > b[4*i-1 -: 4];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/game_sequencer_bcd3_counter.sv
// Saturating 3-digit BCD up-counter with synchronous clear.
// Increment ripples digit-wise (9 -> 0 with carry); holds once q equals sat.
module bcd3_counter
    import game_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    input  logic [11:0] sat,
    output logic [11:0] q
);

    logic [11:0] q_inc;
    logic        carry;

    always_comb begin
        q_inc = q;
        carry = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == BCD_DIGIT_MAX) begin
                    q_inc[4*i +: 4] = '0;
                end else begin
                    q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != sat))
            q <= q_inc;
    end

endmodule

// File: rtl/game_sequencer.sv
// WAIT/FLYING/DEAD game controller: flap pulses, BCD score, dead-screen lockout.
// Define HIGH_SCORE_EN to keep a best score; otherwise best_bcd is tied to 0.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned DEAD_FRAMES   = 60,
    parameter int unsigned FLAP_COOLDOWN = 2,
    parameter int unsigned SCORE_MAX     = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_restart,
    input  logic        collide,
    input  logic        pipe_passed,
    output logic [1:0]  state,
    output logic        flap,
    output logic        run_en,
    output logic [11:0] score_bcd,
    output logic [11:0] best_bcd
);

    localparam logic [7:0]  DEAD_LOAD = 8'(DEAD_FRAMES);
    localparam logic [7:0]  COOL_LOAD = 8'(FLAP_COOLDOWN);
    localparam logic [11:0] SCORE_SAT = to_bcd3(SCORE_MAX);

    state_t     state_q, state_d;
    logic       btn_q;
    logic       btn_edge;
    logic [7:0] cool_q, cool_d;
    logic [7:0] lock_q, lock_d;
    logic       flap_d, run_en_d;
    logic       score_clr, score_inc;

    assign btn_edge = btn_up & ~btn_q;
    assign state    = state_q;

    // State register, with the edge detector, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_WAIT;
            btn_q   <= 1'b0;
            cool_q  <= '0;
            lock_q  <= '0;
            flap    <= 1'b0;
            run_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_up;
            cool_q  <= cool_d;
            lock_q  <= lock_d;
            flap    <= flap_d;
            run_en  <= run_en_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        lock_d  = lock_q;
        if (btn_restart) begin
            state_d = ST_WAIT;
            cool_d  = '0;
            lock_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (btn_edge) begin
                        state_d = ST_FLY;
                        cool_d  = COOL_LOAD;
                    end
                end
                ST_FLY: begin
                    if (collide) begin
                        state_d = ST_DEAD;
                        lock_d  = DEAD_LOAD;
                    end else if (btn_edge && (cool_q == '0)) begin
                        cool_d = COOL_LOAD;
                    end else if (frame_tick && (cool_q != '0)) begin
                        cool_d = cool_q - 8'd1;
                    end
                end
                ST_DEAD: begin
                    if (btn_edge && (lock_q == '0))
                        state_d = ST_WAIT;
                    else if (frame_tick && (lock_q != '0))
                        lock_d = lock_q - 8'd1;
                end
                default: begin
                    state_d = ST_WAIT;
                    cool_d  = '0;
                    lock_d  = '0;
                end
            endcase
        end
    end

    // Output decode; collide in FLYING suppresses both flap and scoring
    always_comb begin
        flap_d    = 1'b0;
        score_inc = 1'b0;
        score_clr = 1'b0;
        if (btn_restart) begin
            score_clr = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    flap_d    = btn_edge;
                    score_clr = 1'b1;
                end
                ST_FLY: begin
                    if (!collide) begin
                        flap_d    = btn_edge && (cool_q == '0);
                        score_inc = pipe_passed;
                    end
                end
                ST_DEAD: score_clr = btn_edge && (lock_q == '0);
                default: score_clr = 1'b1;
            endcase
        end
        run_en_d = (state_d == ST_FLY);
    end

    bcd3_counter u_score (
        .clk (clk),
        .rst (rst),
        .clr (score_clr),
        .inc (score_inc),
        .sat (SCORE_SAT),
        .q   (score_bcd)
    );

`ifdef HIGH_SCORE_EN
    logic        dead_entry_q;
    logic [11:0] best_q;

    // Compare one cycle after entering DEAD, when the score is already frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dead_entry_q <= 1'b0;
            best_q       <= '0;
        end else begin
            dead_entry_q <= (state_d == ST_DEAD) && (state_q != ST_DEAD);
            if (dead_entry_q && bcd_gt(score_bcd, best_q))
                best_q <= score_bcd;
        end
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = '0;
`endif

endmodule
